// File: rtl/clint_mh.sv
// clint_mh: multi-hart core-local interruptor with mtime, per-hart mtimecmp/msip, and a simplified AXI-lite port.
// Build option: define CLINT_MTIME_WR_EN to make mtime writable; otherwise mtime writes are acknowledged and ignored.
module clint_mh #(
  parameter int unsigned NHART    = 1,
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned DATA_W   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         raddr,
  input  logic [2:0]          rsize,
  input  logic                raddr_valid,
  output logic                raddr_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rdata_valid,
  input  logic                rdata_ready,
  input  logic [63:0]         waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wreq_valid,
  output logic                wreq_ready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic [NHART-1:0]    mtip,
  output logic [NHART-1:0]    msip
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_MSIP  = 2'd1,
    SEL_CMP   = 2'd2,
    SEL_MTIME = 2'd3
  } sel_e;

  typedef struct packed {
    sel_e       sel;
    logic [3:0] idx;
    logic       hi;
  } dec_t;

  // Any byte inside a register selects it; hi marks the upper 32-bit lane of a msip word.
  function automatic dec_t decode(input logic [63:0] addr);
    logic [63:0] off;
    dec_t        d;
    off   = addr - BASE;
    d.sel = SEL_NONE;
    d.idx = off[5:2];
    d.hi  = off[2];
    if (off[63:16] != 48'd0) begin
      d.sel = SEL_NONE;
    end else if (off[15:2] < 14'(NHART)) begin
      d.sel = SEL_MSIP;
    end else if ((off[15:3] >= 13'h0800) && (off[15:3] < 13'(13'h0800 + NHART))) begin
      d.sel = SEL_CMP;
      d.idx = off[6:3];
    end else if (off[15:3] == 13'h17FF) begin
      d.sel = SEL_MTIME;
    end else begin
      d.sel = SEL_NONE;
    end
    return d;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  logic [PW-1:0]    presc_r;
  logic [63:0]      mtime_r;
  logic [63:0]      mtimecmp_r [NHART];
  logic [NHART-1:0] msip_r;
  logic [NHART-1:0] mtip_r;
  logic [63:0]      rdata_r;
  logic [1:0]       rresp_r;
  logic             rdata_valid_r;
  logic [1:0]       bresp_r;
  logic             bvalid_r;
  logic             tick_s;
  logic             rd_err_s;
  logic [63:0]      rd_val_s;
  dec_t             rd_dec_s;
  dec_t             wr_dec_s;

  assign tick_s      = (presc_r == PW'(TICK_DIV - 1));
  assign raddr_ready = raddr_valid & (~rdata_valid_r | rdata_ready);
  assign wreq_ready  = wreq_valid & ~bvalid_r;
  assign rd_dec_s    = decode(raddr);
  assign wr_dec_s    = decode(waddr);

  // Read mux over current register values; misaligned or unmapped returns an error with zero data.
  always_comb begin
    rd_val_s = 64'd0;
    rd_err_s = 1'b0;
    if ((rsize > 3'd3) || ((raddr & ((64'd1 << rsize) - 64'd1)) != 64'd0)) begin
      rd_err_s = 1'b1;
    end else begin
      case (rd_dec_s.sel)
        SEL_MSIP: begin
          for (int h = 0; h < NHART; h++) begin
            rd_val_s = (rd_dec_s.idx == 4'(h)) ?
                       (rd_dec_s.hi ? {31'd0, msip_r[h], 32'd0} : {63'd0, msip_r[h]}) : rd_val_s;
          end
        end
        SEL_CMP: begin
          for (int h = 0; h < NHART; h++) begin
            rd_val_s = (rd_dec_s.idx == 4'(h)) ? mtimecmp_r[h] : rd_val_s;
          end
        end
        SEL_MTIME: rd_val_s = mtime_r;
        default:   rd_err_s = 1'b1;
      endcase
    end
  end

  // Timebase and register file; a write to mtime overrides a same-cycle tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= '0;
      mtime_r <= 64'd0;
      msip_r  <= '0;
      for (int h = 0; h < NHART; h++) mtimecmp_r[h] <= '1;
    end else begin
      presc_r <= tick_s ? '0 : presc_r + PW'(1);
      if (tick_s) mtime_r <= mtime_r + 64'd1;
      if (wreq_ready) begin
        case (wr_dec_s.sel)
          SEL_MSIP: begin
            for (int h = 0; h < NHART; h++) begin
              if (wr_dec_s.idx == 4'(h)) begin
                if (wr_dec_s.hi) begin
                  if (wstrb[4]) msip_r[h] <= wdata[32];
                end else if (wstrb[0]) begin
                  msip_r[h] <= wdata[0];
                end
              end
            end
          end
          SEL_CMP: begin
            for (int h = 0; h < NHART; h++) begin
              if (wr_dec_s.idx == 4'(h)) mtimecmp_r[h] <= merge(mtimecmp_r[h], wdata, wstrb);
            end
          end
          SEL_MTIME: begin
`ifdef CLINT_MTIME_WR_EN
            mtime_r <= merge(mtime_r, wdata, wstrb);
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Timer interrupt compare, one cycle behind its operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtip_r <= '0;
    end else begin
      for (int h = 0; h < NHART; h++) mtip_r[h] <= (mtime_r >= mtimecmp_r[h]);
    end
  end

  // Read response register, held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_valid_r <= 1'b0;
      rdata_r       <= 64'd0;
      rresp_r       <= RESP_OKAY;
    end else if (raddr_ready) begin
      rdata_valid_r <= 1'b1;
      rdata_r       <= rd_val_s;
      rresp_r       <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
    end else if (rdata_ready) begin
      rdata_valid_r <= 1'b0;
    end
  end

  // Write response register, held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_r <= 1'b0;
      bresp_r  <= RESP_OKAY;
    end else if (wreq_ready) begin
      bvalid_r <= 1'b1;
      bresp_r  <= (wr_dec_s.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else if (bready) begin
      bvalid_r <= 1'b0;
    end
  end

  assign rdata       = rdata_r;
  assign rresp       = rresp_r;
  assign rdata_valid = rdata_valid_r;
  assign bresp       = bresp_r;
  assign bvalid      = bvalid_r;
  assign mtip        = mtip_r;
  assign msip        = msip_r;

endmodule

// File: tb/tb_clint_mh.sv
// Self-checking bench for clint_mh: directed steps plus random traffic against a cycle-count based reference model.
module tb_clint_mh;
  localparam int NH = 2;
  localparam int D  = 4;
  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

  logic clk, rst;
  logic [63:0] raddr, waddr, wdata, rdata;
  logic [2:0] rsize;
  logic raddr_valid, raddr_ready, rdata_valid, rdata_ready;
  logic [7:0] wstrb;
  logic wreq_valid, wreq_ready, bvalid, bready;
  logic [1:0] rresp, bresp;
  logic [NH-1:0] mtip, msip;

  clint_mh #(.NHART(NH), .BASE(BASE), .TICK_DIV(D), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .raddr(raddr), .rsize(rsize), .raddr_valid(raddr_valid), .raddr_ready(raddr_ready),
    .rdata(rdata), .rresp(rresp), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wreq_valid(wreq_valid), .wreq_ready(wreq_ready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .mtip(mtip), .msip(msip));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mtime is derived from the number of clock edges since reset release.
  int k = 0;
  int k_base = 0;
  logic [63:0] mt_base = 64'd0;
  logic [63:0] cmp_m [NH];
  logic [NH-1:0] msip_m;
  logic [63:0] exp_rdata, last_rdata;
  logic [1:0] exp_rresp, exp_bresp, last_rresp, last_bresp;
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mtime_at(input int kk);
    return mt_base + 64'(kk / D) - 64'(k_base / D);
  endfunction

  function automatic logic [63:0] bmerge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] m;
    m = 64'd0;
    for (int b = 0; b < 8; b++) if (s[b]) m = m | (64'hFF << (8 * b));
    return (d & m) | (o & ~m);
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] a, input logic [2:0] sz, output logic [1:0] resp);
    logic [63:0] off;
    int h;
    off = a - BASE;
    resp = 2'b10;
    if (sz > 3'd3 || (a % (64'd1 << sz)) != 64'd0) return 64'd0;
    if (off < 64'(4 * NH)) begin
      h = int'(off / 4);
      resp = 2'b00;
      return (h % 2 == 1) ? (64'(msip_m[h]) << 32) : 64'(msip_m[h]);
    end
    if (off >= 64'h4000 && off < 64'h4000 + 64'(8 * NH)) begin
      resp = 2'b00;
      return cmp_m[int'((off - 64'h4000) / 8)];
    end
    if (off >= 64'hBFF8 && off < 64'hC000) begin
      resp = 2'b00;
      return mtime_at(k);
    end
    return 64'd0;
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] off;
    int h;
    off = a - BASE;
    exp_bresp = 2'b00;
    if (off < 64'(4 * NH)) begin
      h = int'(off / 4);
      if (s[4 * (h % 2)]) msip_m[h] = d[32 * (h % 2)];
    end else if (off >= 64'h4000 && off < 64'h4000 + 64'(8 * NH)) begin
      h = int'((off - 64'h4000) / 8);
      cmp_m[h] = bmerge(cmp_m[h], d, s);
    end else if (off >= 64'hBFF8 && off < 64'hC000) begin
`ifdef CLINT_MTIME_WR_EN
      mt_base = bmerge(mtime_at(k - 1), d, s);
      k_base = k;
`endif
    end else begin
      exp_bresp = 2'b10;
    end
  endtask

  // One clock: predict, advance, update model, then check the interrupt lines.
  task automatic tick();
    logic [NH-1:0] nxt;
    logic wacc, racc;
    logic [63:0] rexp;
    logic [1:0] rr;
    #1;
    for (int h = 0; h < NH; h++) nxt[h] = !rst && (mtime_at(k) >= cmp_m[h]);
    wacc = !rst && wreq_valid && wreq_ready;
    racc = !rst && raddr_valid && raddr_ready;
    rexp = 64'd0;
    rr = 2'b00;
    if (racc) rexp = model_read(raddr, rsize, rr);
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0; k_base = 0; mt_base = 64'd0; msip_m = '0;
      for (int h = 0; h < NH; h++) cmp_m[h] = '1;
    end else begin
      k++;
      if (racc) begin exp_rdata = rexp; exp_rresp = rr; end
      if (wacc) model_write(waddr, wdata, wstrb);
    end
    chk("mtip", 64'(mtip), 64'(nxt));
    chk("msip", 64'(msip), 64'(msip_m));
  endtask

  task automatic do_read(input string tag, input logic [63:0] a, input logic [2:0] sz);
    raddr = a; rsize = sz; raddr_valid = 1'b1; rdata_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 64'(raddr_ready), 64'd1);
    tick();
    raddr_valid = 1'b0;
    chk({tag, "_rvalid"}, 64'(rdata_valid), 64'd1);
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_rresp"}, 64'(rresp), 64'(exp_rresp));
    last_rdata = rdata; last_rresp = rresp;
    tick();
    chk({tag, "_rdrop"}, 64'(rdata_valid), 64'd0);
  endtask

  task automatic do_write(input string tag, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    waddr = a; wdata = d; wstrb = s; wreq_valid = 1'b1; bready = 1'b1;
    #1 chk({tag, "_wrdy"}, 64'(wreq_ready), 64'd1);
    tick();
    wreq_valid = 1'b0;
    chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    chk({tag, "_bresp"}, 64'(bresp), 64'(exp_bresp));
    last_bresp = bresp;
    tick();
    chk({tag, "_bdrop"}, 64'(bvalid), 64'd0);
  endtask

  initial begin
    logic [63:0] m0, v, a;
    int guard, ka, op, h, sz, off;
    for (int i = 0; i < NH; i++) cmp_m[i] = '1;
    msip_m = '0;
    rst = 1'b1; raddr = 64'd0; rsize = 3'd0; raddr_valid = 1'b0; rdata_ready = 1'b1;
    waddr = 64'd0; wdata = 64'd0; wstrb = 8'd0; wreq_valid = 1'b0; bready = 1'b1;
    repeat (3) tick();
    chk("rst_rvalid", 64'(rdata_valid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_rready", 64'(raddr_ready), 64'd0);
    rst = 1'b0;
    while (k < 10) tick();
    do_read("mtime10", BASE + 64'hBFF8, 3'd3);
    chk("mtime10_val", last_rdata, 64'(10 / D));

    do_write("msip0_set", BASE, 64'hFFFF_FFFF, 8'h0F);
    chk("msip0_set_out", 64'(msip), 64'h1);
    do_read("msip0_rd", BASE, 3'd2);
    chk("msip0_rd_val", last_rdata, 64'h1);
    do_write("msip1_set", BASE + 64'd4, 64'h1_0000_0000, 8'hF0);
    chk("msip1_set_out", 64'(msip), 64'h3);
    do_write("msip0_clr", BASE, 64'd0, 8'h0F);
    chk("msip0_clr_out", 64'(msip), 64'h2);
    do_write("msip1_clr", BASE + 64'd4, 64'd0, 8'hF0);

    do_write("cmp1_20", BASE + 64'h4008, 64'h20, 8'hFF);
    guard = 0;
    while (mtime_at(k) != 64'h20 && guard < 500) begin tick(); guard++; end
    chk("cmp1_timeout", 64'(guard < 500), 64'd1);
    chk("mtip_pre", 64'(mtip), 64'h0);
    tick();
    chk("mtip_hit", 64'(mtip), 64'h2);
    do_write("cmp1_ones", BASE + 64'h4008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    chk("mtip_drop", 64'(mtip), 64'h0);

    do_read("mt_s0", BASE + 64'hBFF8, 3'd3);
    m0 = last_rdata;
    for (int i = 0; i < 19; i++) do_read("mt_s", BASE + 64'hBFF8, 3'd3);
    do_read("mt_s40", BASE + 64'hBFF8, 3'd3);
    chk("mt_40cyc_delta", last_rdata - m0, 64'd10);

    raddr = BASE + 64'h4000; rsize = 3'd3; raddr_valid = 1'b1; rdata_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_rready", 64'(raddr_ready), 64'd0);
      chk("hold_rvalid", 64'(rdata_valid), 64'd1);
      chk("hold_rdata", rdata, exp_rdata);
      tick();
    end
    raddr_valid = 1'b0; rdata_ready = 1'b1;
    tick();
    chk("hold_release", 64'(rdata_valid), 64'd0);
    do_read("unmapped_rd", BASE + 64'h8000, 3'd3);
    chk("unmapped_rresp", 64'(last_rresp), 64'h2);
    chk("unmapped_rdata", last_rdata, 64'd0);
    do_read("misalign_rd", BASE + 64'h4004, 3'd3);
    chk("misalign_rresp", 64'(last_rresp), 64'h2);
    do_read("outside_rd", BASE - 64'd8, 3'd3);
    do_write("unmapped_wr", BASE + 64'h8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    chk("unmapped_bresp", 64'(last_bresp), 64'h2);

    do_write("mtime_wr", BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    chk("mtime_wr_bresp", 64'(last_bresp), 64'h0);
    ka = k;
    do_read("mtime_after_wr", BASE + 64'hBFF8, 3'd3);
`ifndef CLINT_MTIME_WR_EN
    chk("mtime_unchanged", last_rdata, 64'(ka / D));
`endif
    repeat (4) do_read("mtime_roll", BASE + 64'hBFF8, 3'd3);

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 4);
      h = $urandom_range(0, NH - 1);
      case (op)
        0: begin
          v = mtime_at(k) + 64'($urandom_range(0, 8)) - 64'd4;
          if ($urandom_range(0, 3) == 0) v = {$urandom, $urandom};
          do_write("rnd_cmp", BASE + 64'h4000 + 64'(8 * h), v, 8'($urandom_range(0, 255)));
        end
        1: do_write("rnd_msip", BASE + 64'(4 * h), {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        2: begin
          sz = $urandom_range(0, 3);
          off = $urandom_range(0, 7);
          if ($urandom_range(0, 3) != 0) off = off & ~((1 << sz) - 1);
          case ($urandom_range(0, 3))
            0: a = BASE + 64'(4 * h) + 64'(off);
            1: a = BASE + 64'h4000 + 64'(8 * h) + 64'(off);
            2: a = BASE + 64'hBFF8 + 64'(off);
            default: a = BASE + 64'($urandom_range(0, 16'hFFFF));
          endcase
          do_read("rnd_rd", a, 3'(sz));
        end
        3: repeat ($urandom_range(1, 4)) tick();
        default: begin
          if ($urandom_range(0, 1) == 0)
            do_write("rnd_mtime", BASE + 64'hBFF8, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
          else
            do_write("rnd_unmapped", BASE + 64'h1_0000 + 64'($urandom_range(0, 255)), 64'd1, 8'hFF);
        end
      endcase
    end

    raddr = BASE + 64'hBFF8; rsize = 3'd3; raddr_valid = 1'b1; rdata_ready = 1'b0;
    waddr = BASE; wdata = 64'd1; wstrb = 8'h01; wreq_valid = 1'b1; bready = 1'b0;
    tick();
    raddr_valid = 1'b0; wreq_valid = 1'b0; rst = 1'b1;
    tick();
    chk("midrst_rvalid", 64'(rdata_valid), 64'd0);
    chk("midrst_bvalid", 64'(bvalid), 64'd0);
    rst = 1'b0; rdata_ready = 1'b1; bready = 1'b1;
    repeat (6) tick();
    do_read("post_rst_mtime", BASE + 64'hBFF8, 3'd3);
    do_read("post_rst_cmp0", BASE + 64'h4000, 3'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
